alu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the 16-bit combinational ALU.
- Covers the same twelve operations plus a signed compare, generalised in WIDTH.
- Multiply, divide and modulo are iterative, so they add no wide combinational paths.
- Sits between the register-file read stage and write-back, with valid/ready handshakes on both sides so the control FSM can stall on long operations.

---
 rtl/alu_seq_if.sv | 30 +++
 rtl/alu_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
// master: the issuing stage (drives operands, accepts results).
// slave:  the ALU itself.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             div_zero;
    logic             illegal;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, result, zero, neg, carry, div_zero, illegal
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, result, zero, neg, carry, div_zero, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish in one cycle. MUL (shift-add) and DIV/MOD
// (restoring) iterate WIDTH times, so they add no wide combinational paths.
// Optional macro FAST_MUL_EN: MUL becomes a single-cycle combinational
// multiply; results are identical either way.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_MOD  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_SLT  = 4'b1100;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             div_zero_q, div_zero_d;
    logic             illegal_q, illegal_d;
    logic [3:0]       op_q, op_d;
    // opa: multiplicand (MUL) or dividend shifting into quotient (DIV/MOD)
    // opb: multiplier (MUL) or divisor (DIV/MOD)
    // acc: product accumulator (MUL) or partial remainder (DIV/MOD)
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic             accept;
    logic             div_op;
    logic             iter_op;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] fast_res;
    logic             fast_carry;

    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_diff;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    assign accept = bus.in_valid && (state_q == S_IDLE);
    assign div_op = (bus.opcode == OP_DIV) || (bus.opcode == OP_MOD);
`ifdef FAST_MUL_EN
    assign iter_op = div_op;
`else
    assign iter_op = div_op || (bus.opcode == OP_MUL);
`endif

    // Single-cycle datapath, evaluated on the live inputs at accept time
    always_comb begin
        add_full   = {1'b0, bus.a} + {1'b0, bus.b};
        sub_full   = {1'b0, bus.a} - {1'b0, bus.b};
        shamt      = bus.b[SHW-1:0];
        fast_res   = '0;
        fast_carry = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                fast_res   = add_full[WIDTH-1:0];
                fast_carry = add_full[WIDTH];
            end
            OP_SUB: begin
                // bit WIDTH of the extended difference is the borrow
                fast_res   = sub_full[WIDTH-1:0];
                fast_carry = sub_full[WIDTH];
            end
`ifdef FAST_MUL_EN
            OP_MUL:  fast_res = bus.a * bus.b;
`endif
            OP_AND:  fast_res = bus.a & bus.b;
            OP_OR:   fast_res = bus.a | bus.b;
            OP_NOT:  fast_res = ~bus.a;
            OP_SHL:  fast_res = bus.a << shamt;
            OP_SHR:  fast_res = bus.a >> shamt;
            OP_SRA:  fast_res = $signed(bus.a) >>> shamt;
            OP_SLTU: fast_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_SLT:  fast_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: fast_res = '0;
        endcase
    end

    // One iteration step of shift-add multiply and restoring divide
    always_comb begin
        mul_acc_next = opb_q[0] ? (acc_q + opa_q) : acc_q;
        rem_shift    = {acc_q, opa_q[WIDTH-1]};
        rem_ge       = (rem_shift >= {1'b0, opb_q});
        // when rem_ge the true difference is < divisor, so the low bits suffice
        rem_diff     = rem_shift[WIDTH-1:0] - opb_q;
        rem_next     = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
        quo_next     = {opa_q[WIDTH-2:0], rem_ge};
    end

    // Control FSM next-state, operand capture and result/flag update
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        carry_d    = carry_q;
        div_zero_d = div_zero_q;
        illegal_d  = illegal_q;
        op_d       = op_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d       = bus.opcode;
                    carry_d    = 1'b0;
                    div_zero_d = 1'b0;
                    illegal_d  = 1'b0;
                    if (div_op && (bus.b == '0)) begin
                        result_d   = (bus.opcode == OP_DIV) ? '1 : bus.a;
                        div_zero_d = 1'b1;
                        state_d    = S_DONE;
                    end else if (iter_op) begin
                        opa_d   = bus.a;
                        opb_d   = bus.b;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_BUSY;
                    end else begin
                        result_d  = fast_res;
                        carry_d   = fast_carry;
                        illegal_d = (bus.opcode > OP_SLT);
                        state_d   = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc_next;
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end else begin
                    acc_d = rem_next;
                    opa_d = quo_next;
                end
                if (cnt_q == '1) begin
                    state_d = S_DONE;
                    if (op_q == OP_MUL) begin
                        result_d = mul_acc_next;
                    end else if (op_q == OP_DIV) begin
                        result_d = quo_next;
                    end else begin
                        result_d = rem_next;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        zero_d = (result_d == '0);
        neg_d  = result_d[WIDTH-1];
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            result_q   <= '0;
            zero_q     <= 1'b1;
            neg_q      <= 1'b0;
            carry_q    <= 1'b0;
            div_zero_q <= 1'b0;
            illegal_q  <= 1'b0;
            op_q       <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
            carry_q    <= carry_d;
            div_zero_q <= div_zero_d;
            illegal_q  <= illegal_d;
            op_q       <= op_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.carry     = carry_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq at WIDTH=16.
module tb_alu_seq;
    localparam int W = 16;
`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 17;
`endif
    localparam int DIV_LAT = 17;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, ".in_ready"},  32'(bus.in_ready),  32'd1);
        check_val({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        check_val({tag, ".result"},    32'(bus.result),    32'd0);
        check_val({tag, ".zero"},      32'(bus.zero),      32'd1);
        check_val({tag, ".neg"},       32'(bus.neg),       32'd0);
        check_val({tag, ".carry"},     32'(bus.carry),     32'd0);
        check_val({tag, ".div_zero"},  32'(bus.div_zero),  32'd0);
        check_val({tag, ".illegal"},   32'(bus.illegal),   32'd0);
    endtask

    // Issue one op, wait for out_valid (bounded), check everything, drain.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp_res, input logic exp_carry,
                          input logic exp_dz, input logic exp_ill, input int exp_lat);
        int lat;
        check_val({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.a        = av;
        bus.b        = bv;
        bus.opcode   = op;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        // scramble inputs: the op must use the values captured at accept
        bus.in_valid = 1'b0;
        bus.a        = 16'h5A5A;
        bus.b        = 16'hA5A5;
        bus.opcode   = 4'h0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, ".latency"},  32'(lat),           32'(exp_lat));
        check_val({tag, ".result"},   32'(bus.result),    32'(exp_res));
        check_val({tag, ".zero"},     32'(bus.zero),      32'(exp_res == '0));
        check_val({tag, ".neg"},      32'(bus.neg),       32'(exp_res[W-1]));
        check_val({tag, ".carry"},    32'(bus.carry),     32'(exp_carry));
        check_val({tag, ".div_zero"}, 32'(bus.div_zero),  32'(exp_dz));
        check_val({tag, ".illegal"},  32'(bus.illegal),   32'(exp_ill));
        $display("txn %-10s op=%b a=%h b=%h result=%h c=%b dz=%b ill=%b lat=%0d",
                 tag, op, av, bv, bus.result, bus.carry, bus.div_zero, bus.illegal, lat);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_val({tag, ".idle_after"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int ov_seen;
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.opcode    = '0;
        #12;
        check_reset_state("reset");
        $display("txn reset      outputs at reset values");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        //      tag          op       a         b         result    c     dz    ill   lat
        run_op("add_wrap",  4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1);
        run_op("sub_borrow",4'b0001, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1);
        run_op("sub_pos",   4'b0001, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, 1);
        run_op("mul_300",   4'b0010, 16'd300,  16'd300,  16'h5F90, 1'b0, 1'b0, 1'b0, MUL_LAT);
        run_op("mul_wrap",  4'b0010, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, MUL_LAT);
        run_op("div_1000_7",4'b0011, 16'd1000, 16'd7,    16'd142,  1'b0, 1'b0, 1'b0, DIV_LAT);
        run_op("mod_1000_7",4'b0100, 16'd1000, 16'd7,    16'd6,    1'b0, 1'b0, 1'b0, DIV_LAT);
        run_op("div_by0",   4'b0011, 16'd5,    16'd0,    16'hFFFF, 1'b0, 1'b1, 1'b0, 1);
        run_op("mod_by0",   4'b0100, 16'd5,    16'd0,    16'd5,    1'b0, 1'b1, 1'b0, 1);
        run_op("div_small", 4'b0011, 16'd7,    16'd1000, 16'd0,    1'b0, 1'b0, 1'b0, DIV_LAT);
        run_op("mod_small", 4'b0100, 16'd7,    16'd1000, 16'd7,    1'b0, 1'b0, 1'b0, DIV_LAT);
        run_op("div_max",   4'b0011, 16'hFFFF, 16'd1,    16'hFFFF, 1'b0, 1'b0, 1'b0, DIV_LAT);
        run_op("and",       4'b0101, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 1);
        run_op("or",        4'b0110, 16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0, 1'b0, 1'b0, 1);
        run_op("not",       4'b0111, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 1'b0, 1);
        run_op("shl_hi_b",  4'b1000, 16'h0001, 16'h0024, 16'h0010, 1'b0, 1'b0, 1'b0, 1);
        run_op("shl_zero",  4'b1000, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0, 1'b0, 1);
        run_op("shr",       4'b1001, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0, 1);
        run_op("sra",       4'b1010, 16'h8000, 16'h0013, 16'hF000, 1'b0, 1'b0, 1'b0, 1);
        run_op("slt",       4'b1100, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1);
        run_op("sltu",      4'b1011, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1);
        run_op("illegal_d", 4'b1101, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b0, 1'b1, 1);
        run_op("or_after",  4'b0110, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 1);

        // Backpressure: result held while out_ready is low, new requests ignored
        bus.a = 16'd3; bus.b = 16'd4; bus.opcode = 4'b0000; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        check_val("bp.valid", 32'(bus.out_valid), 32'd1);
        bus.a = 16'd9; bus.b = 16'd1; bus.opcode = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_val("bp.hold_result", 32'(bus.result),    32'd7);
            check_val("bp.hold_valid",  32'(bus.out_valid), 32'd1);
            check_val("bp.hold_ready",  32'(bus.in_ready),  32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_val("bp.idle_ready", 32'(bus.in_ready),  32'd1);
        check_val("bp.idle_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        check_val("bp.no_extra",   32'(bus.out_valid), 32'd0);
        $display("txn backpress  result=%h held 5 cycles, released", bus.result);

        // Reset while a DIV is iterating
        bus.a = 16'd1000; bus.b = 16'd7; bus.opcode = 4'b0011; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check_val("rst_busy.in_ready", 32'(bus.in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("rst_busy");
        @(posedge clk); #1;
        rst = 1'b0;
        ov_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) ov_seen++;
        end
        check_val("rst_busy.no_valid", 32'(ov_seen), 32'd0);
        $display("txn rst_busy   DIV discarded, out_valid count=%0d", ov_seen);

        run_op("illegal_e", 4'b1110, 16'hABCD, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
